// File: rtl/mem_arbiter_pkg.sv
// Shared configuration for the memory arbiter: state encoding, defaults and
// line-address helpers.
package mem_arbiter_pkg;

  localparam int unsigned DefDelay     = 9;
  localparam int unsigned DefLineWords = 4;

  // Counter widths sized for the legal parameter ranges (DELAY <= 255, LINE_WORDS <= 16).
  localparam int unsigned CntW  = 8;
  localparam int unsigned BeatW = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StXfer = 2'd2,
    StDone = 2'd3
  } arb_state_e;

  typedef enum logic {
    ReqIc = 1'b0,
    ReqDc = 1'b1
  } req_e;

  // Clears the byte-in-line bits so a transfer always starts at word 0 of the line.
  function automatic logic [31:0] line_base(input logic [31:0] addr,
                                            input int unsigned line_words);
    logic [31:0] span;
    span = 32'(line_words) << 2;
    return addr & ~(span - 32'd1);
  endfunction

endpackage

// File: rtl/mem_latency_timer.sv
// Down-counter modelling main-memory access latency; done_o is high once the
// loaded count has run down to zero. Holds its value while stalled.
module mem_latency_timer
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned Width = CntW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             stall_i,
  output logic             done_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!stall_i) begin
      if (load_i) begin
        count_d = load_val_i;
      end else if (count_q != '0) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) main-memory arbiter with round-robin grant,
// fixed access latency and a LINE_WORDS-beat line transfer.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DELAY      = DefDelay,
  parameter int unsigned LINE_WORDS = DefLineWords
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  input  logic        dc_req,
  input  logic        dc_we,
  input  logic [31:0] dc_addr,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic        ic_ready,
  output logic        dc_ready,
  output logic        busy
);

  arb_state_e       state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic             we_q, we_d;
  logic [BeatW-1:0] beat_q, beat_d;
  // Owner of the current transfer, which is also the last requester granted.
  req_e             owner_q, owner_d;

  logic timer_load;
  logic timer_done;
  logic pick_dc;

  mem_latency_timer #(
    .Width (CntW)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (timer_load),
    .load_val_i (CntW'(DELAY - 1)),
    .stall_i    (stall),
    .done_o     (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    we_d       = we_q;
    beat_d     = beat_q;
    owner_d    = owner_q;
    timer_load = 1'b0;
    // On a tie the requester not granted last wins.
    pick_dc    = dc_req && (!ic_req || (owner_q == ReqIc));

    if (!stall) begin
      unique case (state_q)
        StIdle: begin
          if (ic_req || dc_req) begin
            timer_load = 1'b1;
            state_d    = StWait;
            if (pick_dc) begin
              owner_d = ReqDc;
              base_d  = line_base(dc_addr, LINE_WORDS);
              we_d    = dc_we;
            end else begin
              owner_d = ReqIc;
              base_d  = line_base(ic_addr, LINE_WORDS);
              we_d    = 1'b0;
            end
          end
        end
        StWait: begin
          if (timer_done) begin
            state_d = StXfer;
            beat_d  = '0;
          end
        end
        StXfer: begin
          if (beat_q == BeatW'(LINE_WORDS - 1)) begin
            state_d = StDone;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      base_q  <= '0;
      we_q    <= 1'b0;
      beat_q  <= '0;
      owner_q <= ReqIc;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      we_q    <= we_d;
      beat_q  <= beat_d;
      owner_q <= owner_d;
    end
  end

  assign mem_en   = (state_q == StXfer);
  assign mem_we   = mem_en && we_q;
  assign mem_addr = mem_en ? (base_q + (32'(beat_q) << 2)) : 32'd0;
  assign ic_ready = (state_q == StDone) && (owner_q == ReqIc);
  assign dc_ready = (state_q == StDone) && (owner_q == ReqDc);
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (DELAY=9, LINE_WORDS=4): a vector table of
// complete transfers plus hand sequences for tie, re-grant and reset abort.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        dc_req;
  logic        dc_we;
  logic [31:0] dc_addr;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic        ic_ready;
  logic        dc_ready;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(
    .DELAY      (9),
    .LINE_WORDS (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .ic_req   (ic_req),
    .ic_addr  (ic_addr),
    .dc_req   (dc_req),
    .dc_we    (dc_we),
    .dc_addr  (dc_addr),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .ic_ready (ic_ready),
    .dc_ready (dc_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        dc_req;
    logic        dc_we;
    logic [31:0] dc_addr;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic        ic_rdy;
    logic        dc_rdy;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // p counts unstalled edges since the grant edge (inclusive): WAIT for p=1..9,
  // beats for p=10..13, DONE at p=14, IDLE at p=15. The requester drops its
  // request once it has seen ready.
  task automatic add_xfer(input logic is_dc, input logic we, input logic [31:0] req_addr,
                          input logic [31:0] base, input int stall_at, input int stall_len);
    int   p;
    int   p_prev;
    logic req;
    vec_t v;
    p = 0;
    for (int e = 0; e < 40 && p < 15; e++) begin
      v.stall   = (e >= stall_at) && (e < stall_at + stall_len);
      p_prev    = p;
      if (!v.stall) p++;
      req       = (p_prev < 14);
      v.ic_req  = !is_dc && req;
      v.ic_addr = is_dc ? 32'd0 : req_addr;
      v.dc_req  = is_dc && req;
      v.dc_we   = is_dc && we;
      v.dc_addr = is_dc ? req_addr : 32'd0;
      v.en      = (p >= 10) && (p <= 13);
      v.we      = v.en && we;
      v.addr    = v.en ? base + 32'((p - 10) * 4) : 32'd0;
      v.ic_rdy  = (p == 14) && !is_dc;
      v.dc_rdy  = (p == 14) && is_dc;
      v.busy    = (p >= 1) && (p <= 14);
      vecs.push_back(v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, " mem_addr"}, mem_addr, 32'd0);
    chk({tag, " ic_ready"}, 32'(ic_ready), 32'd0);
    chk({tag, " dc_ready"}, 32'(dc_ready), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc_edge;
    int ic_edge;
    int r_edge;

    // Table: plain I-fetch line, D writeback, stall in WAIT, unaligned D read,
    // stall during XFER.
    add_xfer(1'b0, 1'b0, 32'h0000_1004, 32'h0000_1000, 100, 0);
    add_xfer(1'b1, 1'b1, 32'h0000_2000, 32'h0000_2000, 100, 0);
    add_xfer(1'b0, 1'b0, 32'h0000_3018, 32'h0000_3010, 3, 3);
    add_xfer(1'b1, 1'b0, 32'h0000_403C, 32'h0000_4030, 100, 0);
    add_xfer(1'b1, 1'b0, 32'h0000_5004, 32'h0000_5000, 11, 2);

    reset   = 1'b0;
    stall   = 1'b0;
    ic_req  = 1'b0;
    ic_addr = 32'd0;
    dc_req  = 1'b0;
    dc_we   = 1'b0;
    dc_addr = 32'd0;
    #3;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Simultaneous requests straight after reset: D-cache first.
    ic_req  = 1'b1;
    ic_addr = 32'h0000_6000;
    dc_req  = 1'b1;
    dc_addr = 32'h0000_7000;
    dc_edge = -1;
    ic_edge = -1;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      if (dc_ready && dc_edge < 0) begin
        dc_edge = e;
        dc_req  = 1'b0;
      end
      if (ic_ready && ic_edge < 0) begin
        ic_edge = e;
        ic_req  = 1'b0;
      end
      if (ic_edge >= 0) break;
    end
    chk("tie dc_ready edge", 32'(dc_edge), 32'd13);
    chk("tie ic_ready edge", 32'(ic_edge), 32'd28);
    @(posedge clk);
    #1;
    chk("tie idle busy", 32'(busy), 32'd0);

    foreach (vecs[i]) begin
      stall   = vecs[i].stall;
      ic_req  = vecs[i].ic_req;
      ic_addr = vecs[i].ic_addr;
      dc_req  = vecs[i].dc_req;
      dc_we   = vecs[i].dc_we;
      dc_addr = vecs[i].dc_addr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(vecs[i].en));
      chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].we));
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].addr);
      chk($sformatf("v%0d ic_ready", i), 32'(ic_ready), 32'(vecs[i].ic_rdy));
      chk($sformatf("v%0d dc_ready", i), 32'(dc_ready), 32'(vecs[i].dc_rdy));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
    end
    stall  = 1'b0;
    ic_req = 1'b0;
    dc_req = 1'b0;
    dc_we  = 1'b0;

    // Request held through DONE: no re-grant on the DONE edge, re-grant one edge later.
    ic_req  = 1'b1;
    ic_addr = 32'h0000_8008;
    r_edge  = -1;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk);
      #1;
      if (ic_ready) begin
        r_edge = e;
        break;
      end
    end
    chk("hold ic_ready edge", 32'(r_edge), 32'd13);
    @(posedge clk);
    #1;
    chk("hold no double grant busy", 32'(busy), 32'd0);
    chk("hold no double grant ic_ready", 32'(ic_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("hold regrant busy", 32'(busy), 32'd1);
    chk("hold regrant mem_en", 32'(mem_en), 32'd0);

    // Advance to beat 2 of the re-granted transfer, then abort with reset.
    repeat (11) @(posedge clk);
    #1;
    chk("abort beat2 mem_en", 32'(mem_en), 32'd1);
    chk("abort beat2 mem_addr", mem_addr, 32'h0000_8008);
    #2;
    reset  = 1'b0;
    ic_req = 1'b0;
    #1;
    chk_all_zero("abort");
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    ic_req  = 1'b1;
    ic_addr = 32'h0000_9000;
    r_edge  = -1;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk);
      #1;
      if (e == 0) chk("post-abort grant busy", 32'(busy), 32'd1);
      if (ic_ready) begin
        r_edge = e;
        ic_req = 1'b0;
        break;
      end
    end
    chk("post-abort ic_ready edge", 32'(r_edge), 32'd13);
    @(posedge clk);
    #1;
    chk("post-abort idle busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
